// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the UART FIFO: two valid/ready requesters,
// bounded bursts, flag throttling, saturating per-requester counts and a sticky overflow flag.
module fifo_wr_arbiter #(
   parameter int DATA_W    = 8,
   parameter int BURST_MAX = 16,
   parameter int CNT_W     = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              fifo_almost_full,
   input  logic              fifo_full,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wr_data,
   output logic [1:0]        grant,
   output logic [CNT_W-1:0]  wr_cnt0,
   output logic [CNT_W-1:0]  wr_cnt1,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

   // State encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;

   state_t            state_q, state_d;
   logic              last_srv_q, last_srv_d;
   logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
   logic              fifo_wr_en_q, fifo_wr_en_d;
   logic [DATA_W-1:0] fifo_wr_data_q, fifo_wr_data_d;
   logic [CNT_W-1:0]  wr_cnt0_q, wr_cnt0_d;
   logic [CNT_W-1:0]  wr_cnt1_q, wr_cnt1_d;
   logic              ovf_q, ovf_d;

   logic stall, acc0, acc1, acc, cur_valid, oth_valid, burst_done;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      stall      = fifo_almost_full | fifo_full;
      req0_ready = (state_q == G0) & ~stall;
      req1_ready = (state_q == G1) & ~stall;
      acc0       = req0_valid & req0_ready;
      acc1       = req1_valid & req1_ready;
      acc        = acc0 | acc1;
      cur_valid  = (state_q == G1) ? req1_valid : req0_valid;
      oth_valid  = (state_q == G1) ? req0_valid : req1_valid;
      burst_done = acc & (burst_cnt_q == BURST_LAST);

      state_d     = state_q;
      last_srv_d  = last_srv_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         IDLE: begin
            burst_cnt_d = '0;
            if (req0_valid & req1_valid) begin
               state_d    = last_srv_q ? G0 : G1;
               last_srv_d = ~last_srv_q;
            end else if (req0_valid) begin
               state_d    = G0;
               last_srv_d = 1'b0;
            end else if (req1_valid) begin
               state_d    = G1;
               last_srv_d = 1'b1;
            end
         end
         G0, G1: begin
            // Release either hands over, re-enters the same grant, or idles.
            if (burst_done | ~cur_valid) begin
               burst_cnt_d = '0;
               if (oth_valid) begin
                  state_d    = (state_q == G0) ? G1 : G0;
                  last_srv_d = (state_q == G0);
               end else if (~cur_valid) begin
                  state_d = IDLE;
               end
            end else if (acc) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      fifo_wr_en_d   = acc;
      fifo_wr_data_d = acc1 ? req1_data : (acc0 ? req0_data : fifo_wr_data_q);

      if (ovf_clr) begin
         wr_cnt0_d = acc0 ? CNT_W'(1) : '0;
         wr_cnt1_d = acc1 ? CNT_W'(1) : '0;
      end else begin
         wr_cnt0_d = acc0 ? sat_inc(wr_cnt0_q) : wr_cnt0_q;
         wr_cnt1_d = acc1 ? sat_inc(wr_cnt1_q) : wr_cnt1_q;
      end

      ovf_d = (fifo_wr_en_q & fifo_full) | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q        <= IDLE;
         last_srv_q     <= 1'b1;
         burst_cnt_q    <= '0;
         fifo_wr_en_q   <= 1'b0;
         fifo_wr_data_q <= '0;
         wr_cnt0_q      <= '0;
         wr_cnt1_q      <= '0;
         ovf_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_srv_q     <= last_srv_d;
         burst_cnt_q    <= burst_cnt_d;
         fifo_wr_en_q   <= fifo_wr_en_d;
         fifo_wr_data_q <= fifo_wr_data_d;
         wr_cnt0_q      <= wr_cnt0_d;
         wr_cnt1_q      <= wr_cnt1_d;
         ovf_q          <= ovf_d;
      end
   end

   assign grant        = state_q;
   assign fifo_wr_en   = fifo_wr_en_q;
   assign fifo_wr_data = fifo_wr_data_q;
   assign wr_cnt0      = wr_cnt0_q;
   assign wr_cnt1      = wr_cnt1_q;
   assign ovf          = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed and random stimulus compared every cycle
// against a transaction-level ownership model of the arbiter.
module tb_fifo_wr_arbiter;

   localparam int DW   = 8;
   localparam int BM   = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [DW-1:0] req0_data = '0, req1_data = '0;
   logic          req0_ready, req1_ready;
   logic          fifo_almost_full = 1'b0, fifo_full = 1'b0;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_wr_data;
   logic [1:0]    grant;
   logic [CW-1:0] wr_cnt0, wr_cnt1;
   logic          ovf;
   logic          ovf_clr = 1'b0;

   fifo_wr_arbiter #(.DATA_W(DW), .BURST_MAX(BM), .CNT_W(CW)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant(grant),
      .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 sys_clk = ~sys_clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: owner is -1 (nobody), 0 or 1; words served in the current burst.
   int m_own, m_last, m_burst, m_wdata, m_cnt0, m_cnt1;
   bit m_wen, m_ovf, m_acc0, m_acc1;

   task automatic model_reset();
      m_own = -1; m_last = 1; m_burst = 0; m_wdata = 0;
      m_cnt0 = 0; m_cnt1 = 0; m_wen = 0; m_ovf = 0; m_acc0 = 0; m_acc1 = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit stall;
      stall = fifo_almost_full || fifo_full;
      chk("grant", grant, (m_own == 0) ? 1 : (m_own == 1) ? 2 : 0);
      chk("req0_ready", req0_ready, (m_own == 0) && !stall);
      chk("req1_ready", req1_ready, (m_own == 1) && !stall);
      chk("fifo_wr_en", fifo_wr_en, m_wen);
      chk("fifo_wr_data", fifo_wr_data, m_wdata);
      chk("wr_cnt0", wr_cnt0, m_cnt0);
      chk("wr_cnt1", wr_cnt1, m_cnt1);
      chk("ovf", ovf, m_ovf);
   endtask

   task automatic model_update();
      bit stall, v0, v1, cur, oth, rel;
      if (!sys_rst_n) begin
         model_reset();
         return;
      end
      stall  = fifo_almost_full || fifo_full;
      v0     = req0_valid;
      v1     = req1_valid;
      m_acc0 = (m_own == 0) && v0 && !stall;
      m_acc1 = (m_own == 1) && v1 && !stall;
      m_ovf  = (m_wen && fifo_full) || (m_ovf && !ovf_clr);
      m_wen  = m_acc0 || m_acc1;
      if (m_acc0) m_wdata = req0_data;
      if (m_acc1) m_wdata = req1_data;
      if (ovf_clr) begin
         m_cnt0 = m_acc0 ? 1 : 0;
         m_cnt1 = m_acc1 ? 1 : 0;
      end else begin
         if (m_acc0) m_cnt0 = (m_cnt0 + 1 > CMAX) ? CMAX : m_cnt0 + 1;
         if (m_acc1) m_cnt1 = (m_cnt1 + 1 > CMAX) ? CMAX : m_cnt1 + 1;
      end
      if (m_own < 0) begin
         if (v0 && v1)  m_own = 1 - m_last;
         else if (v0)   m_own = 0;
         else if (v1)   m_own = 1;
         if (m_own >= 0) begin m_last = m_own; m_burst = 0; end
      end else begin
         cur = (m_own == 0) ? v0 : v1;
         oth = (m_own == 0) ? v1 : v0;
         if (m_acc0 || m_acc1) m_burst++;
         rel = (m_burst == BM) || !cur;
         if (rel) begin
            m_burst = 0;
            if (oth) begin m_own = 1 - m_own; m_last = m_own; end
            else if (!cur) m_own = -1;
         end
      end
   endtask

   task automatic cyc();
      @(negedge sys_clk);
      check_all();
      model_update();
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      int w;
      model_reset();

      // Reset state
      repeat (2) cyc();
      sys_rst_n = 1'b1;
      cyc();

      // Single requester stream of 40 words
      w = 0;
      req0_valid = 1'b1;
      for (int i = 0; i < 200 && w < 40; i++) begin
         req0_data = DW'(w);
         cyc();
         if (m_acc0) w++;
      end
      chk("stream_words", w, 40);
      req0_valid = 1'b0;
      repeat (3) cyc();
      chk("stream_cnt_sat", wr_cnt0, CMAX);

      // Contention, then backpressure mid-burst
      ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         req0_data = DW'($urandom); req1_data = DW'($urandom);
         if (i >= 10 && i < 15) fifo_almost_full = 1'b1;
         else fifo_almost_full = 1'b0;
         cyc();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) cyc();

      // Early release: to req1, then to idle
      req0_valid = 1'b1; req0_data = 8'hA5;
      repeat (3) cyc();
      req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'h5A;
      cyc();
      chk("early_rel_g1", grant, 2'b10);
      req1_valid = 1'b0;
      repeat (2) cyc();
      req0_valid = 1'b1; req0_data = 8'h3C;
      repeat (3) cyc();
      req0_valid = 1'b0;
      cyc();
      chk("early_rel_idle", grant, 2'b00);

      // Overflow: full while a write is issued, sticky, set beats clear
      req0_valid = 1'b1;
      repeat (3) cyc();
      fifo_full = 1'b1; cyc(); fifo_full = 1'b0;
      repeat (3) cyc();
      fifo_full = 1'b1; ovf_clr = 1'b1; cyc();
      fifo_full = 1'b0; cyc();
      req0_valid = 1'b0; cyc();
      ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
      cyc();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_data  = DW'($urandom);
         req1_data  = DW'($urandom);
         fifo_almost_full = ($urandom_range(0, 9) == 0);
         fifo_full  = ($urandom_range(0, 19) == 0);
         ovf_clr    = ($urandom_range(0, 29) == 0);
         cyc();
      end
      fifo_almost_full = 1'b0; fifo_full = 1'b0; ovf_clr = 1'b0;

      // Reset asserted mid-burst during G1
      req0_valid = 1'b0; req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin req1_data = DW'($urandom); cyc(); end
      chk("pre_rst_grant", grant, 2'b10);
      sys_rst_n = 1'b0;
      #1;
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_grant", grant, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_cnt0", wr_cnt0, 0);
      chk("rst_cnt1", wr_cnt1, 0);
      chk("rst_ovf", ovf, 0);
      model_reset();
      repeat (2) cyc();
      req0_valid = 1'b1;
      sys_rst_n = 1'b1;
      cyc();
      chk("post_rst_grant", grant, 2'b01);
      repeat (10) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
